// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: timing presets, total-length constants and a width helper shared by
// the raster timing generator and its axis counters.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_t;

    localparam axis_t H_640 = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam axis_t V_480 = '{active: 480, fp: 10, sync: 2, bp: 33};
    localparam axis_t H_800 = '{active: 800, fp: 40, sync: 128, bp: 88};
    localparam axis_t V_600 = '{active: 600, fp: 1, sync: 4, bp: 23};

    function automatic int unsigned axis_total(input axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

    function automatic int unsigned clog2_u(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

    localparam int unsigned H_TOTAL_640 = axis_total(H_640);
    localparam int unsigned V_TOTAL_480 = axis_total(V_480);
    localparam int unsigned H_TOTAL_800 = axis_total(H_800);
    localparam int unsigned V_TOTAL_600 = axis_total(V_600);

endpackage

// File: rtl/vga_axis_ctr.sv
// vga_axis_ctr: one raster axis counter with wrap strobe and registered active/sync/position
// flags derived from the next-state count.
module vga_axis_ctr
    import vga_timing_pkg::*;
#(
    parameter int unsigned LEN        = H_TOTAL_640,
    parameter int unsigned ACTIVE     = H_640.active,
    parameter int unsigned SYNC_START = H_640.active + H_640.fp,
    parameter int unsigned SYNC_END   = H_640.active + H_640.fp + H_640.sync,
    parameter int          W          = clog2_u(H_TOTAL_640)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic         o_wrap,
    output logic [W-1:0] o_pos,
    output logic         o_active,
    output logic         o_sync
);

    localparam logic [W-1:0] LAST  = W'(LEN - 1);
    localparam logic [W-1:0] ACT   = W'(ACTIVE);
    localparam logic [W-1:0] ALAST = W'(ACTIVE - 1);
    localparam logic [W-1:0] SS    = W'(SYNC_START);
    localparam logic [W-1:0] SE    = W'(SYNC_END);

    logic [W-1:0] cnt_q, cnt_d, pos_q;
    logic         active_q, sync_q;

    // o_wrap ignores i_clr so the parent can tell a real wrap from a restart
    always_comb begin
        o_wrap = i_en && (cnt_q == LAST);
        cnt_d  = (i_clr || o_wrap) ? '0 : i_en ? cnt_q + W'(1) : cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            pos_q    <= '0;
            active_q <= 1'b1;
            sync_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pos_q    <= (cnt_d < ACT) ? cnt_d : ALAST;
            active_q <= cnt_d < ACT;
            sync_q   <= (cnt_d >= SS) && (cnt_d < SE);
        end
    end

    assign o_pos    = pos_q;
    assign o_active = active_q;
    assign o_sync   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator (sync, active/blank, line/frame/animate
// pulses, clamped x/y). Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit o_frame_cnt output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_640.active,
    parameter int unsigned H_FP     = H_640.fp,
    parameter int unsigned H_SYNC   = H_640.sync,
    parameter int unsigned H_BP     = H_640.bp,
    parameter int unsigned V_ACTIVE = V_480.active,
    parameter int unsigned V_FP     = V_480.fp,
    parameter int unsigned V_SYNC   = V_480.sync,
    parameter int unsigned V_BP     = V_480.bp,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int          XW       = clog2_u(H_TOTAL_640),
    parameter int          YW       = clog2_u(V_TOTAL_480)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_pix_stb,
    input  logic          i_frame_rst,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_active,
    output logic          o_blanking,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_animate,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   o_frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic          h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
    logic [YW-1:0] v_pos;
    logic          line_q, line_d, frame_q, frame_d, anim_q, anim_d;

    vga_axis_ctr #(
        .LEN(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP),
        .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .W(XW)
    ) u_h (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_frame_rst), .i_en(i_pix_stb),
        .o_wrap(h_wrap), .o_pos(o_x), .o_active(h_act), .o_sync(h_sync)
    );

    vga_axis_ctr #(
        .LEN(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP),
        .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .W(YW)
    ) u_v (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_frame_rst), .i_en(h_wrap),
        .o_wrap(v_wrap), .o_pos(v_pos), .o_active(v_act), .o_sync(v_sync)
    );

    // v_pos is clamped, so v_act is needed to pin the last active line exactly
    always_comb begin
        line_d  = i_frame_rst | h_wrap;
        frame_d = i_frame_rst | v_wrap;
        anim_d  = ~i_frame_rst & h_wrap & v_act & (v_pos == YW'(V_ACTIVE - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            anim_q  <= 1'b0;
        end else begin
            line_q  <= line_d;
            frame_q <= frame_d;
            anim_q  <= anim_d;
        end
    end

    assign o_hs          = h_sync ^ ~HS_POL;
    assign o_vs          = v_sync ^ ~VS_POL;
    assign o_active      = h_act & v_act;
    assign o_blanking    = ~o_active;
    assign o_line_start  = line_q;
    assign o_frame_start = frame_q;
    assign o_animate     = anim_q;
    assign o_y           = v_pos;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    always_comb fcnt_d = i_frame_rst ? '0 : fcnt_q + 16'(v_wrap);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) fcnt_q <= '0;
        else          fcnt_q <= fcnt_d;
    end

    assign o_frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a 640x480 instance and a tiny 8/2/2/2 x 4/1/1/1 instance against a
// linear-pixel-index model every cycle, plus hand-computed literal expectations.
module tb_vga_timing_gen;

    localparam int HA[2]  = '{640, 8};
    localparam int HF[2]  = '{16, 2};
    localparam int HSW[2] = '{96, 2};
    localparam int VA[2]  = '{480, 4};
    localparam int VF[2]  = '{10, 1};
    localparam int VSW[2] = '{2, 1};
    localparam int HT[2]  = '{800, 14};
    localparam int NT[2]  = '{420000, 98};
    localparam bit HP[2]  = '{1'b0, 1'b1};
    localparam bit VP[2]  = '{1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stb[2], frst[2];
    logic       hs[2], vs[2], act[2], blank[2], ls[2], fs[2], an[2];
    logic [9:0] x[2], y[2];
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc[2];
`endif

    int total = 0, bad = 0;
    int p[2], efc[2], nls[2], nfs[2], nan[2];
    bit els[2], efs[2], ean[2];

    always #5 clk = ~clk;

    vga_timing_gen u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb[0]), .i_frame_rst(frst[0]),
        .o_hs(hs[0]), .o_vs(vs[0]), .o_active(act[0]), .o_blanking(blank[0]),
        .o_line_start(ls[0]), .o_frame_start(fs[0]), .o_animate(an[0]), .o_x(x[0]), .o_y(y[0])
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .o_frame_cnt(fc[0])
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .XW(10), .YW(10)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb[1]), .i_frame_rst(frst[1]),
        .o_hs(hs[1]), .o_vs(vs[1]), .o_active(act[1]), .o_blanking(blank[1]),
        .o_line_start(ls[1]), .o_frame_start(fs[1]), .o_animate(an[1]), .o_x(x[1]), .o_y(y[1])
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .o_frame_cnt(fc[1])
`endif
    );

    task automatic chk(input string nm, input integer a, input integer e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            p[i] = 0; efc[i] = 0; els[i] = 0; efs[i] = 0; ean[i] = 0;
        end
    endtask

    task automatic model_step();
        bit eol;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            eol = (p[i] % HT[i]) == HT[i] - 1;
            if (frst[i]) begin
                p[i] = 0; els[i] = 1; efs[i] = 1; ean[i] = 0; efc[i] = 0;
            end else if (stb[i]) begin
                els[i] = eol;
                ean[i] = eol && (p[i] / HT[i]) == VA[i] - 1;
                efs[i] = p[i] == NT[i] - 1;
                if (efs[i]) efc[i] = (efc[i] + 1) % 65536;
                p[i] = (p[i] + 1) % NT[i];
            end else begin
                els[i] = 0; efs[i] = 0; ean[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        int h, v;
        bit a;
        for (int i = 0; i < 2; i++) begin
            h = p[i] % HT[i];
            v = p[i] / HT[i];
            a = h < HA[i] && v < VA[i];
            chk($sformatf("hs%0d", i), hs[i],
                (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HSW[i]) ? int'(HP[i]) : int'(!HP[i]));
            chk($sformatf("vs%0d", i), vs[i],
                (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VSW[i]) ? int'(VP[i]) : int'(!VP[i]));
            chk($sformatf("active%0d", i), act[i], int'(a));
            chk($sformatf("blanking%0d", i), blank[i], int'(!a));
            chk($sformatf("x%0d", i), x[i], h < HA[i] ? h : HA[i] - 1);
            chk($sformatf("y%0d", i), y[i], v < VA[i] ? v : VA[i] - 1);
            chk($sformatf("line_start%0d", i), ls[i], int'(els[i]));
            chk($sformatf("frame_start%0d", i), fs[i], int'(efs[i]));
            chk($sformatf("animate%0d", i), an[i], int'(ean[i]));
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk($sformatf("frame_cnt%0d", i), fc[i], efc[i]);
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        for (int i = 0; i < 2; i++) begin
            nls[i] += int'(ls[i]);
            nfs[i] += int'(fs[i]);
            nan[i] += int'(an[i]);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            nls[i] = 0; nfs[i] = 0; nan[i] = 0;
        end
    endtask

    initial begin
        int t1, t2, nslow;
        rst_n = 1'b0;
        stb = '{1'b0, 1'b0};
        frst = '{1'b0, 1'b0};
        model_reset();
        repeat (3) begin
            @(negedge clk);
            compare_all();
        end
        chk("rst_active0", act[0], 1);
        chk("rst_blank0", blank[0], 0);
        chk("rst_hs0", hs[0], 1);
        chk("rst_vs0", vs[0], 1);
        chk("rst_hs1", hs[1], 0);
        chk("rst_vs1", vs[1], 0);
        chk("rst_x0", x[0], 0);
        chk("rst_fs0", fs[0], 0);

        rst_n = 1'b1;
        stb[0] = 1'b1;
        run(640);
        chk("x_after640", x[0], 639);
        chk("active_after640", act[0], 0);
        chk("blank_after640", blank[0], 1);
        run(16);
        chk("hs_h656", hs[0], 0);
        run(95);
        chk("hs_h751", hs[0], 0);
        run(1);
        chk("hs_h752", hs[0], 1);
        run(48);
        chk("ls_line1", ls[0], 1);
        chk("y_line1", y[0], 1);
        chk("x_line1", x[0], 0);
        stb[0] = 1'b0;

        clear_counts();
        stb[1] = 1'b1;
        run(9);
        chk("hs1_h9", hs[1], 0);
        run(1);
        chk("hs1_h10", hs[1], 1);
        run(2);
        chk("hs1_h12", hs[1], 0);
        run(58);
        chk("vs1_line5", vs[1], 1);
        chk("y1_line5", y[1], 3);
        chk("active1_line5", act[1], 0);
        run(14);
        chk("vs1_line6", vs[1], 0);
        run(210);
        chk("fs1_3frames", fs[1], 1);
        chk("ls1_3frames", ls[1], 1);
        chk("n_frame_start1", nfs[1], 3);
        chk("n_line_start1", nls[1], 21);
        chk("n_animate1", nan[1], 3);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt1_3", fc[1], 3);
`endif

        t1 = -1; t2 = -1; nslow = 0;
        for (int k = 0; k < 784; k++) begin
            stb[1] = (k % 4) == 0;
            tick();
            if (fs[1] === 1'b1) begin
                nslow++;
                if (t1 < 0) t1 = k; else t2 = k;
            end
        end
        chk("n_frame_start_slow", nslow, 2);
        chk("frame_len_slow", t2 - t1, 392);

        stb[0] = 1'b1;
        run(300);
        chk("x0_before_frst", x[0], 300);
        frst[0] = 1'b1;
        tick();
        frst[0] = 1'b0;
        chk("frst_x0", x[0], 0);
        chk("frst_y0", y[0], 0);
        chk("frst_fs0", fs[0], 1);
        run(1);
        chk("frst_next_x0", x[0], 1);
        chk("frst_next_fs0", fs[0], 0);

        stb[0] = 1'b0;
        stb[1] = 1'b1;
        run(30);
        frst[1] = 1'b1;
        tick();
        frst[1] = 1'b0;
        chk("frst_fs1", fs[1], 1);
        chk("frst_x1", x[1], 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frst_cnt1", fc[1], 0);
`endif
        run(98);
        chk("fs1_after_frst_frame", fs[1], 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("cnt1_after_frst_frame", fc[1], 1);
`endif

        stb[0] = 1'b1;
        run(10);
        stb[1] = 1'b0;
        run(489);
        chk("x0_h500", x[0], 500);
        chk("hs1_h10_pre_rst", hs[1], 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_x0", x[0], 0);
        chk("async_hs1", hs[1], 0);
        chk("async_x1", x[1], 0);
        compare_all();
        tick();
        rst_n = 1'b1;
        tick();
        chk("first_stb_x0", x[0], 1);
        run(5);
        chk("stb6_x0", x[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
